// File: rtl/barcode_pkg.sv
// Shared constants, enums and key-decoding helpers for the barcode assembler.
package barcode_pkg;

    localparam logic [7:0] ASCII_ENTER = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_R_UC  = 8'h52;
    localparam logic [7:0] ASCII_R_LC  = 8'h72;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    typedef enum logic [1:0] {
        RADIX_DEC = 2'b00,
        RADIX_HEX = 2'b01,
        RADIX_B36 = 2'b10,
        RADIX_RSV = 2'b11
    } radix_e;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CONVERT = 2'd1,
        ST_PUSH    = 2'd2
    } state_e;

    function automatic logic [5:0] radix_value(input radix_e radix);
        case (radix)
            RADIX_DEC: return 6'd10;
            RADIX_B36: return 6'd36;
            default:   return 6'd16;
        endcase
    endfunction

    // Returns {valid, value}; letters decode to 10..35 and are valid only below the radix.
    function automatic logic [6:0] ascii_to_digit(input logic [7:0] ascii, input radix_e radix);
        logic [5:0] value;
        value = 6'd63;
        if (ascii >= 8'h30 && ascii <= 8'h39)
            value = 6'(ascii - 8'h30);
        else if (ascii >= 8'h41 && ascii <= 8'h5A)
            value = 6'(ascii - 8'h37);
        else if (ascii >= 8'h61 && ascii <= 8'h7A)
            value = 6'(ascii - 8'h57);
        return {(value < radix_value(radix)), value};
    endfunction

endpackage

// File: rtl/barcode_fifo.sv
// Synchronous FIFO with full/empty/level; a push into a full FIFO is accepted when a pop happens in the same cycle.
module barcode_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/barcode_assembler.sv
// Collects ASCII digit keys, converts them with a multi-cycle Horner loop and queues finished codes.
module barcode_assembler
    import barcode_pkg::*;
#(
    parameter int CODE_W     = 32,
    parameter int MAX_DIGITS = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DEDUP      = 1
) (
    input  logic                              CLOCK_50,
    input  logic                              RESET,
    input  logic [7:0]                        key_ascii,
    input  logic                              key_strobe,
    input  logic [1:0]                        radix_mode,
    input  logic                              clr_flags,
    output logic [CODE_W-1:0]                 code_data,
    output logic                              code_valid,
    input  logic                              code_ready,
    output logic                              busy,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              err_digit,
    output logic                              err_drop,
    output logic                              err_dup,
    output logic [1:0]                        state_dbg
);

    localparam int CW = $clog2(MAX_DIGITS+1);
    localparam int AW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      idx_q;
    logic [5:0]         digit_mem [MAX_DIGITS];
    logic [CODE_W-1:0]  acc_q, acc_mul, acc_next;
    radix_e             radix_q;
    logic [1:0]         mode_q;
    logic [CODE_W-1:0]  last_code_q;
    logic               last_valid_q;

    radix_e             cur_radix;
    logic [6:0]         key_dec;
    logic               key_is_clear;
    logic               radix_chg;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;

    logic               digit_we;
    logic               start_cvt;
    logic               push_req;
    logic               set_err_digit;
    logic               set_err_drop;
    logic               set_err_dup;

    assign cur_radix    = radix_e'(radix_mode);
    assign key_dec      = ascii_to_digit(key_ascii, cur_radix);
    assign key_is_clear = (cur_radix == RADIX_B36) ? (key_ascii == ASCII_MINUS)
                                                   : (key_ascii == ASCII_R_UC || key_ascii == ASCII_R_LC);
    assign radix_chg    = (radix_mode != mode_q);

    // Output handshake: code_data is the FIFO head whenever code_valid is high and holds until
    // the consumer raises code_ready; an entry leaves on every edge where code_valid && code_ready.
    assign pop          = code_valid && code_ready;
    assign code_valid   = !fifo_empty;
    assign busy         = (state_q != ST_COLLECT);
    assign digit_count  = count_q;
    assign state_dbg    = state_q;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET)
            state_q <= ST_COLLECT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        digit_we      = 1'b0;
        start_cvt     = 1'b0;
        push_req      = 1'b0;
        set_err_digit = 1'b0;
        set_err_drop  = 1'b0;
        set_err_dup   = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                // A radix switch invalidates buffered digits and swallows a coincident key.
                if (radix_chg && count_q != '0) begin
                    count_d = '0;
                end else if (key_strobe) begin
                    if (key_dec[6]) begin
                        if (count_q == MAX_CNT) begin
                            set_err_digit = 1'b1;
                        end else begin
                            digit_we = 1'b1;
                            count_d  = count_q + CW'(1);
                        end
                    end else if (key_ascii == ASCII_BS) begin
                        if (count_q != '0)
                            count_d = count_q - CW'(1);
                    end else if (key_is_clear) begin
                        count_d = '0;
                    end else if (key_ascii == ASCII_ENTER && count_q != '0) begin
                        start_cvt = 1'b1;
                        state_d   = ST_CONVERT;
                    end
                end
            end
            ST_CONVERT: begin
                if (idx_q == count_q - CW'(1))
                    state_d = ST_PUSH;
            end
            ST_PUSH: begin
                count_d = '0;
                state_d = ST_COLLECT;
                if (DEDUP != 0 && last_valid_q && acc_q == last_code_q)
                    set_err_dup = 1'b1;
                else if (fifo_full && !pop)
                    set_err_drop = 1'b1;
                else
                    push_req = 1'b1;
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // Constant-radix multiply as shift-add, then add the current digit.
    always_comb begin
        case (radix_q)
            RADIX_DEC: acc_mul = (acc_q << 3) + (acc_q << 1);
            RADIX_B36: acc_mul = (acc_q << 5) + (acc_q << 2);
            default:   acc_mul = acc_q << 4;
        endcase
        acc_next = acc_mul + CODE_W'(digit_mem[idx_q[AW-1:0]]);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            count_q      <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            radix_q      <= RADIX_DEC;
            mode_q       <= 2'b00;
            last_code_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            mode_q  <= radix_mode;
            if (start_cvt) begin
                idx_q   <= '0;
                acc_q   <= '0;
                radix_q <= cur_radix;
            end else if (state_q == ST_CONVERT) begin
                acc_q <= acc_next;
                idx_q <= idx_q + CW'(1);
            end
            if (push_req) begin
                last_code_q  <= acc_q;
                last_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (digit_we)
            digit_mem[count_q[AW-1:0]] <= key_dec[5:0];
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            err_digit <= 1'b0;
            err_drop  <= 1'b0;
            err_dup   <= 1'b0;
        end else begin
            if (set_err_digit)  err_digit <= 1'b1;
            else if (clr_flags) err_digit <= 1'b0;
            if (set_err_drop)   err_drop  <= 1'b1;
            else if (clr_flags) err_drop  <= 1'b0;
            if (set_err_dup)    err_dup   <= 1'b1;
            else if (clr_flags) err_dup   <= 1'b0;
        end
    end

    barcode_fifo #(
        .W     (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .push      (push_req),
        .push_data (acc_q),
        .pop       (pop),
        .pop_data  (code_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: doc/barcode_assembler.md
# barcode_assembler

Parametrised key-stream to code assembler that sits between the PS/2 keyboard/scanner front-end (scan-code controller plus key-to-ASCII converter) and the SHA hashing core. It collects ASCII digit strobes in a runtime-selectable radix (decimal, hex, base-36) and supports backspace and clear. On Enter it converts the stored digits to a binary code with a multi-cycle Horner loop. Finished codes are queued in a small FIFO and handed to the hash side over a valid/ready handshake.

## Interface
- CODE_W, 32: width of the assembled code.
- MAX_DIGITS, 8: digit buffer depth, in digits.
- FIFO_DEPTH, 4: number of queued codes; must be a power of two and at least 2.
- DEDUP, 1: when 1, drop a code equal to the last code pushed.
- CLOCK_50  in  1  sole clock; all logic is rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- key_ascii  in  8  ASCII byte from the key converter.
- key_strobe  in  1  one-cycle pulse, synchronous to CLOCK_50; key_ascii is valid in that cycle.
- radix_mode  in  2  00 = decimal, 01 = hex, 10 = base-36, 11 = reserved (treated as hex).
- clr_flags  in  1  one-cycle pulse that clears err_digit, err_drop and err_dup.
- code_data  out  CODE_W  FIFO head.
- code_valid  out  1  FIFO not empty.
- code_ready  in  1  consumer accepts; a pop occurs when code_valid && code_ready.
- busy  out  1  high in CONVERT and PUSH.
- digit_count  out  $clog2(MAX_DIGITS+1)  digits currently buffered.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  entries queued.
- err_digit, err_drop, err_dup  out  1 each  sticky error flags.

## Operation
- States:
  - COLLECT: the reset state.
  - CONVERT: entered on an accepted Enter.
  - PUSH: one cycle, then back to COLLECT.
- Key classification in COLLECT, one action per key_strobe:
  - Digit:
    - Decimal accepts '0'-'9'.
    - Hex accepts '0'-'9', 'A'-'F' and 'a'-'f'.
    - Base-36 accepts '0'-'9', 'A'-'Z' and 'a'-'z'.
    - The digit value (6 bits) is written at index digit_count, then the count is incremented.
    - If digit_count == MAX_DIGITS, the digit is discarded and err_digit is set.
  - Backspace (0x08): digit_count decrements; ignored at 0.
  - Clear: 'R'/'r' in decimal or hex, '-' in base-36. Sets digit_count to 0.
  - Enter (0x0D):
    - If digit_count > 0, latch the radix and go to CONVERT.
    - If digit_count == 0, ignore.
  - Any other byte is ignored.
- A radix_mode change (registered compare) while digit_count > 0 sets digit_count to 0.
- Key strobes arriving in CONVERT or PUSH are dropped silently.
- CONVERT:
  - acc starts at 0 and idx at 0.
  - Each cycle: acc <= acc*radix + digit[idx], then idx++.
  - Arithmetic is modulo 2^CODE_W; no overflow flag.
  - Exit to PUSH after digit_count cycles.
- PUSH:
  - If DEDUP and acc equals the last pushed code (a last-pushed valid bit is cleared by reset), drop the code and set err_dup.
  - Else, if the FIFO is full, drop the code and set err_drop. The pop-same-cycle exception is handled by the FIFO.
  - Otherwise write acc and update the last-pushed register.
  - In every case set digit_count to 0 and return to COLLECT.
- FIFO:
  - A push and a pop in the same cycle are both performed, even when full.
  - Pointers wrap modulo FIFO_DEPTH.
- Error flags: the set has priority over clr_flags in the same cycle.

## Timing
- Reset values:
  - State COLLECT.
  - digit_count, fifo_level, busy, code_valid and all error flags are 0.
  - code_data is 0.
  - The last-pushed register is invalid.
- An Enter strobe at edge k with n digits:
  - CONVERT occupies cycles k+1 to k+n.
  - PUSH is cycle k+n+1.
  - code_valid rises at k+n+2 if the FIFO was empty.
- busy is asserted from k+1 through k+n+1.
- code_data is stable while code_valid && !code_ready.
- A pop at edge p makes the next entry, or code_valid = 0, visible after p.
- RESET asserted mid-CONVERT aborts the conversion. No partial code is written, and the FIFO is emptied.

## Structure
- barcode_pkg holds:
  - ASCII constants for Enter, Backspace, 'R' and '-'.
  - A radix_e enum.
  - The function ascii_to_digit(ascii, radix), returning {valid, value[5:0]}.
  - The function radix_value(radix_e), returning 10, 16 or 36.
- Sub-module barcode_fifo: a parameterised synchronous FIFO (data width and depth) with full, empty, level, and simultaneous push/pop support.
- The top level contains the FSM, the digit buffer, the Horner datapath (constant-radix multiply-add), the dedup register and the flags.

## Test plan
- Hex, keys "1A3f" then Enter, code_ready=1:
  - code_data = 0x00001A3F.
  - code_valid rises exactly 6 cycles after the Enter edge.
- Decimal, "1234", Backspace, "5", Enter → code_data = 0x000004D3 (1235).
- Base-36, "Z1", Enter → 1261 (0x4ED). A '-' before Enter instead clears the buffer, and a following Enter produces nothing.
- Hex, 9 digits "123456789" then Enter, MAX_DIGITS=8 → err_digit=1, code = 0x12345678.
- code_ready=0, push 5 distinct codes, FIFO_DEPTH=4:
  - fifo_level = 4 and err_drop = 1.
  - Draining yields the first 4 codes in order.
- DEDUP=1:
  - Entering "AB" twice yields a single entry and err_dup = 1.
  - RESET asserted during CONVERT of a 5-digit entry leaves fifo_level = 0, state COLLECT and digit_count = 0.
